// File: rtl/shift_pkg.sv
// Shared constants for the universal shift register slice.
// Mode encodings used by the top and its bench.
package shift_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_HOLD = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SHR  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_SHL  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_word_counter.sv
// Counts consecutive shifts and pulses word_done
// for one cycle after every WIDTH-th shift.
module shift_word_counter #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          resetBar,
  input  logic          en,
  input  logic          is_shift,
  input  logic          clear,
  output logic [CW-1:0] shift_cnt,
  output logic          word_done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (!resetBar) begin
      shift_cnt <= '0;
      word_done <= 1'b0;
    end else if (!en) begin
      word_done <= 1'b0;
    end else if (clear) begin
      shift_cnt <= '0;
      word_done <= 1'b0;
    end else if (is_shift) begin
      if (shift_cnt == LAST) begin
        shift_cnt <= '0;
        word_done <= 1'b1;
      end else begin
        shift_cnt <= shift_cnt + 1'b1;
        word_done <= 1'b0;
      end
    end else begin
      word_done <= 1'b0;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register with registered q/qBar.
// Define UNIV_SHIFT_REG_ROTATE_EN to add the rotate input.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              resetBar,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_r,
  input  logic              sin_l,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  input  logic              rotate,
`endif
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qBar,
  output logic              sout_r,
  output logic              sout_l,
  output logic [CW-1:0]     shift_cnt,
  output logic              word_done
);

  logic             is_shr;
  logic             is_shl;
  logic             is_load;
  logic             in_r;
  logic             in_l;
  logic [WIDTH-1:0] nxt;

  assign is_shr  = en && (mode == MODE_SHR);
  assign is_shl  = en && (mode == MODE_SHL);
  assign is_load = en && (mode == MODE_LOAD);

`ifdef UNIV_SHIFT_REG_ROTATE_EN
  assign in_r = rotate ? q[0] : sin_r;
  assign in_l = rotate ? q[WIDTH-1] : sin_l;
`else
  assign in_r = sin_r;
  assign in_l = sin_l;
`endif

  always_comb begin
    nxt = q;
    unique case (1'b1)
      is_shr:  nxt = {in_r, q[WIDTH-1:1]};
      is_shl:  nxt = {q[WIDTH-2:0], in_l};
      is_load: nxt = d;
      default: nxt = q;
    endcase
  end

  // qBar comes from the same next value so it can never diverge from q
  always_ff @(posedge clk) begin
    if (!resetBar) begin
      q    <= RESET_VAL;
      qBar <= ~RESET_VAL;
    end else begin
      q    <= nxt;
      qBar <= ~nxt;
    end
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  shift_word_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk      (clk),
    .resetBar (resetBar),
    .en       (en),
    .is_shift ((mode == MODE_SHR) || (mode == MODE_SHL)),
    .clear    (mode == MODE_LOAD),
    .shift_cnt(shift_cnt),
    .word_done(word_done)
  );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench: two instances (RESET_VAL 0 and 8'h81)
// share stimulus; a monitor checks each edge against the queue.
module tb_univ_shift_reg;
  import shift_pkg::*;

  typedef struct {
    logic [7:0] qa;
    logic [7:0] qb;
    logic [2:0] cnt;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetBar = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = MODE_HOLD;
  logic [7:0] d = '0;
  logic       sin_r = 1'b0;
  logic       sin_l = 1'b0;
  logic       rotate = 1'b0;

  logic [7:0] qa, qbara, qb, qbarb;
  logic       sra, sla, srb, slb;
  logic [2:0] cnta, cntb;
  logic       dna, dnb;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut_a (
    .clk(clk), .resetBar(resetBar), .en(en), .mode(mode),
    .d(d), .sin_r(sin_r), .sin_l(sin_l),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    .rotate(rotate),
`endif
    .q(qa), .qBar(qbara), .sout_r(sra), .sout_l(sla),
    .shift_cnt(cnta), .word_done(dna)
  );

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h81)) dut_b (
    .clk(clk), .resetBar(resetBar), .en(en), .mode(mode),
    .d(d), .sin_r(sin_r), .sin_l(sin_l),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    .rotate(rotate),
`endif
    .q(qb), .qBar(qbarb), .sout_r(srb), .sout_l(slb),
    .shift_cnt(cntb), .word_done(dnb)
  );

  task automatic step(input logic rst_n, input logic e,
                      input logic [1:0] m, input logic [7:0] dv,
                      input logic sr, input logic sl, input logic rot,
                      input logic [7:0] ea, input logic [7:0] eb,
                      input logic [2:0] ec, input logic ed);
    exp_t x;
    @(negedge clk);
    resetBar = rst_n;
    en       = e;
    mode     = m;
    d        = dv;
    sin_r    = sr;
    sin_l    = sl;
    rotate   = rot;
    x.qa = ea; x.qb = eb; x.cnt = ec; x.done = ed;
    sb.push_back(x);
  endtask

  // Monitor: one expected entry per clock edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (qa !== x.qa || qbara !== ~x.qa ||
            sra !== x.qa[0] || sla !== x.qa[7]) begin
          errors++;
          $display("FAIL dut_a_q: q=%h qBar=%h sr=%b sl=%b need q=%h qBar=%h",
                   qa, qbara, sra, sla, x.qa, ~x.qa);
        end
        checks++;
        if (qb !== x.qb || qbarb !== ~x.qb ||
            srb !== x.qb[0] || slb !== x.qb[7]) begin
          errors++;
          $display("FAIL dut_b_q: q=%h qBar=%h sr=%b sl=%b need q=%h qBar=%h",
                   qb, qbarb, srb, slb, x.qb, ~x.qb);
        end
        checks++;
        if (cnta !== x.cnt || cntb !== x.cnt) begin
          errors++;
          $display("FAIL shift_cnt: a=%0d b=%0d need %0d",
                   cnta, cntb, x.cnt);
        end
        checks++;
        if (dna !== x.done || dnb !== x.done) begin
          errors++;
          $display("FAIL word_done: a=%b b=%b need %b",
                   dna, dnb, x.done);
        end
      end
    end
  end

  initial begin
    logic [7:0] e;
    logic [7:0] rot_tab [8];
    rot_tab[0] = 8'h81; rot_tab[1] = 8'h03; rot_tab[2] = 8'h06;
    rot_tab[3] = 8'h0C; rot_tab[4] = 8'h18; rot_tab[5] = 8'h30;
    rot_tab[6] = 8'h60; rot_tab[7] = 8'hC0;

    // 1: reset beats a load request
    for (int i = 0; i < 2; i++)
      step(0, 1, MODE_LOAD, 8'h5A, 0, 0, 0, 8'h00, 8'h81, 0, 0);

    // 2: load A5, eight right shifts with zero fill
    step(1, 1, MODE_LOAD, 8'hA5, 0, 0, 0, 8'hA5, 8'hA5, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      e = 8'hA5 >> k;
      step(1, 1, MODE_SHR, 8'h00, 0, 0, 0, e, e, 3'(k % 8), k == 8);
    end
    step(1, 1, MODE_HOLD, 8'h77, 0, 0, 0, 8'h00, 8'h00, 0, 0);

    // 3: left shifts of ones interleaved with disabled cycles
    step(1, 1, MODE_LOAD, 8'h01, 0, 0, 0, 8'h01, 8'h01, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      e = 8'((9'h002 << k) - 9'h001);
      step(1, 1, MODE_SHL, 8'h00, 0, 1, 0, e, e, 3'(k % 8), k == 8);
      step(1, 0, MODE_LOAD, 8'h55, 0, 1, 0, e, e, 3'(k % 8), 0);
    end

    // 4: load on the wrapping cycle suppresses the pulse
    step(1, 1, MODE_LOAD, 8'h0F, 0, 0, 0, 8'h0F, 8'h0F, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      e = (8'h0F >> k) | (8'hFF << (8 - k));
      step(1, 1, MODE_SHR, 8'h00, 1, 0, 0, e, e, 3'(k), 0);
    end
    step(1, 1, MODE_LOAD, 8'h3C, 0, 0, 0, 8'h3C, 8'h3C, 0, 0);
    step(1, 1, MODE_HOLD, 8'h00, 0, 0, 0, 8'h3C, 8'h3C, 0, 0);

    // 5: reset mid-word discards the count
    step(1, 1, MODE_LOAD, 8'h12, 0, 0, 0, 8'h12, 8'h12, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      e = 8'h12 << k;
      step(1, 1, MODE_SHL, 8'h00, 0, 0, 0, e, e, 3'(k), 0);
    end
    step(0, 1, MODE_SHL, 8'h00, 0, 0, 0, 8'h00, 8'h81, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      e = 8'h81 << k;
      step(1, 1, MODE_SHL, 8'h00, 0, 0, 0, 8'h00, e, 3'(k), 0);
    end

    // back-to-back words with mixed directions
    step(1, 1, MODE_LOAD, 8'hFF, 0, 0, 0, 8'hFF, 8'hFF, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      e = (k >= 8) ? 8'h00 : 8'(8'hFF >> k);
      step(1, 1, MODE_SHR, 8'h00, 0, 0, 0, e, e, 3'(k % 8),
           (k == 8) || (k == 16));
    end
    step(1, 1, MODE_SHL, 8'h00, 0, 1, 0, 8'h01, 8'h01, 1, 0);
    step(1, 1, MODE_SHR, 8'h00, 1, 0, 0, 8'h80, 8'h80, 2, 0);

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    // 6: rotation recirculates the outgoing bit
    step(1, 1, MODE_LOAD, 8'h81, 0, 0, 0, 8'h81, 8'h81, 0, 0);
    step(1, 1, MODE_SHR, 8'h00, 0, 0, 1, 8'hC0, 8'hC0, 1, 0);
    for (int k = 1; k <= 8; k++)
      step(1, 1, MODE_SHL, 8'h00, 0, 0, 1, rot_tab[k-1], rot_tab[k-1],
           3'((k + 1) % 8), k == 7);
`endif

    @(negedge clk);
    en = 1'b0;
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    wait (stim_done);
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, need 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
